// File: rtl/reg_file_tagged_pkg.sv
// Shared core defines for the tagged register file: default widths,
// register-index width derivation and legacy status encodings.
package reg_file_tagged_pkg;

  localparam int RF_TAG_W_DEF = 4;
  localparam int RF_XLEN_DEF  = 32;
  localparam int RF_NREG_DEF  = 32;

  // Legacy status encodings still consumed by older status users.
  typedef enum logic [1:0] {
    RF_NOP      = 2'd0,
    RF_WRITE    = 2'd1,
    RF_FINISHED = 2'd2
  } rf_status_e;

  function automatic int rf_idx_w(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/reg_file_tagged_read_port.sv
// One combinational operand read port with same-cycle commit bypass.
module reg_file_read_port
  import reg_file_tagged_pkg::*;
#(
  parameter int XLEN  = RF_XLEN_DEF,
  parameter int NREG  = RF_NREG_DEF,
  parameter int TAG_W = RF_TAG_W_DEF,
  parameter int IW    = rf_idx_w(NREG)
) (
  input  logic [IW-1:0]          idx,
  input  logic [NREG*XLEN-1:0]   value_flat,
  input  logic [NREG-1:0]        busy_vec,
  input  logic [NREG*TAG_W-1:0]  tag_flat,
  input  logic                   commit_valid,
  input  logic [IW-1:0]          commit_rd,
  input  logic [TAG_W-1:0]       commit_tag,
  input  logic [XLEN-1:0]        commit_data,
  output logic [XLEN-1:0]        data,
  output logic                   busy,
  output logic [TAG_W-1:0]       tag
);

  logic [XLEN-1:0]  ent_value_s;
  logic             ent_busy_s;
  logic [TAG_W-1:0] ent_tag_s;
  logic             bypass_s;

  assign ent_value_s = value_flat[idx*XLEN +: XLEN];
  assign ent_busy_s  = busy_vec[idx];
  assign ent_tag_s   = tag_flat[idx*TAG_W +: TAG_W];

  // Only a commit from the newest writer resolves the operand early.
  assign bypass_s = commit_valid && (commit_rd == idx) && ent_busy_s &&
                    (ent_tag_s == commit_tag);

  always_comb begin
    data = '0;
    busy = 1'b0;
    tag  = '0;
    if (idx == '0) begin
      data = '0;
      busy = 1'b0;
      tag  = '0;
    end else if (bypass_s) begin
      data = commit_data;
      busy = 1'b0;
      tag  = '0;
    end else begin
      data = ent_value_s;
      busy = ent_busy_s;
      tag  = ent_busy_s ? ent_tag_s : '0;
    end
  end

endmodule

// File: rtl/reg_file_tagged.sv
// Architectural register file with per-register busy bit and rename tag,
// NRP bypassing read ports, one commit port and a global rename flush.
module reg_file_tagged
  import reg_file_tagged_pkg::*;
#(
  parameter int XLEN  = RF_XLEN_DEF,
  parameter int NREG  = RF_NREG_DEF,
  parameter int TAG_W = RF_TAG_W_DEF,
  parameter int NRP   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy_in,
  input  logic [NRP*$clog2(NREG)-1:0] rd_idx,
  output logic [NRP*XLEN-1:0]        rd_data,
  output logic [NRP-1:0]             rd_busy,
  output logic [NRP*TAG_W-1:0]       rd_tag,
  input  logic                       issue_valid,
  input  logic [$clog2(NREG)-1:0]    issue_rd,
  input  logic [TAG_W-1:0]           issue_tag,
  input  logic                       commit_valid,
  input  logic [$clog2(NREG)-1:0]    commit_rd,
  input  logic [TAG_W-1:0]           commit_tag,
  input  logic [XLEN-1:0]            commit_data,
  input  logic                       flush
);

  localparam int IW = $clog2(NREG);

  logic [XLEN-1:0]  value_q [NREG];
  logic [XLEN-1:0]  value_d [NREG];
  logic             busy_q  [NREG];
  logic             busy_d  [NREG];
  logic [TAG_W-1:0] tag_q   [NREG];
  logic [TAG_W-1:0] tag_d   [NREG];

  logic [NREG*XLEN-1:0]  value_flat_s;
  logic [NREG-1:0]       busy_vec_s;
  logic [NREG*TAG_W-1:0] tag_flat_s;

  genvar r;
  generate
    for (r = 0; r < NREG; r++) begin : g_reg
      if (r == 0) begin : g_zero
        // x0 is hard-wired: always zero, never busy.
        always_comb begin
          value_d[r] = '0;
          busy_d[r]  = 1'b0;
          tag_d[r]   = '0;
        end
      end else begin : g_live
        logic commit_hit_s;
        logic issue_hit_s;
        assign commit_hit_s = commit_valid && (commit_rd == IW'(r));
        assign issue_hit_s  = issue_valid && (issue_rd == IW'(r));

        always_comb begin
          value_d[r] = value_q[r];
          busy_d[r]  = busy_q[r];
          tag_d[r]   = tag_q[r];
          if (rst) begin
            value_d[r] = '0;
            busy_d[r]  = 1'b0;
            tag_d[r]   = '0;
          end else if (!rdy_in) begin
            value_d[r] = value_q[r];
          end else begin
            // Value write is unconditional; busy clears only for the newest writer.
            if (commit_hit_s) begin
              value_d[r] = commit_data;
              if ((tag_q[r] == commit_tag) && !issue_hit_s) begin
                busy_d[r] = 1'b0;
              end else begin
                busy_d[r] = busy_q[r];
              end
            end else begin
              value_d[r] = value_q[r];
            end
            if (flush) begin
              busy_d[r] = 1'b0;
              tag_d[r]  = '0;
            end else if (issue_hit_s) begin
              busy_d[r] = 1'b1;
              tag_d[r]  = issue_tag;
            end else begin
              tag_d[r]  = tag_q[r];
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        value_q[r] <= value_d[r];
        busy_q[r]  <= busy_d[r];
        tag_q[r]   <= tag_d[r];
      end

      assign value_flat_s[r*XLEN +: XLEN]   = value_q[r];
      assign busy_vec_s[r]                  = busy_q[r];
      assign tag_flat_s[r*TAG_W +: TAG_W]   = tag_q[r];
    end
  endgenerate

  genvar p;
  generate
    for (p = 0; p < NRP; p++) begin : g_rp
      reg_file_read_port #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .TAG_W (TAG_W),
        .IW    (IW)
      ) u_rp (
        .idx          (rd_idx[p*IW +: IW]),
        .value_flat   (value_flat_s),
        .busy_vec     (busy_vec_s),
        .tag_flat     (tag_flat_s),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .commit_data  (commit_data),
        .data         (rd_data[p*XLEN +: XLEN]),
        .busy         (rd_busy[p]),
        .tag          (rd_tag[p*TAG_W +: TAG_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_tagged.sv
// Directed self-checking bench for reg_file_tagged with hand-computed expectations.
module tb_reg_file_tagged;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int TAG_W = 4;
  localparam int NRP = 2;
  localparam int IW = 5;

  logic             clk;
  logic             rst;
  logic             rdy_in;
  logic [NRP*IW-1:0] rd_idx;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]   rd_busy;
  logic [NRP*TAG_W-1:0] rd_tag;
  logic             issue_valid;
  logic [IW-1:0]    issue_rd;
  logic [TAG_W-1:0] issue_tag;
  logic             commit_valid;
  logic [IW-1:0]    commit_rd;
  logic [TAG_W-1:0] commit_tag;
  logic [XLEN-1:0]  commit_data;
  logic             flush;

  int total;
  int bad;
  bit x_chk_en;

  reg_file_tagged #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRP(NRP)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_data(commit_data), .flush(flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic rdchk(input string nm, input int p, input logic [31:0] d,
                       input logic b, input logic [3:0] t);
    chk({nm, "_data"}, rd_data[p*XLEN +: XLEN], d);
    chk({nm, "_busy"}, {31'd0, rd_busy[p]}, {31'd0, b});
    chk({nm, "_tag"},  {28'd0, rd_tag[p*TAG_W +: TAG_W]}, {28'd0, t});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_tag = '0; commit_data = '0;
    flush = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a, input logic [4:0] b);
    rd_idx = {b, a};
    #1;
  endtask

  // Every port is checked for X on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (x_chk_en) chk("no_x", {31'd0, $isunknown({rd_data, rd_busy, rd_tag})}, 32'd0);
  end

  initial begin
    total = 0; bad = 0; x_chk_en = 1'b0;
    rst = 1'b1; rdy_in = 1'b1; rd_idx = '0;
    idle();
    step(); step();
    rst = 1'b0; x_chk_en = 1'b1;

    set_rd(5'd5, 5'd5);
    rdchk("rst_p0", 0, 32'h0, 1'b0, 4'd0);
    rdchk("rst_p1", 1, 32'h0, 1'b0, 4'd0);

    issue_valid = 1'b1; issue_rd = 5'd0; issue_tag = 4'd3;
    step(); idle();
    set_rd(5'd0, 5'd0);
    rdchk("x0_issue", 0, 32'h0, 1'b0, 4'd0);

    issue_valid = 1'b1; issue_rd = 5'd5; issue_tag = 4'd3;
    step(); idle();
    set_rd(5'd5, 5'd0);
    rdchk("x5_busy", 0, 32'h0, 1'b1, 4'd3);
    commit_valid = 1'b1; commit_rd = 5'd5; commit_tag = 4'd3; commit_data = 32'hDEADBEEF;
    #1;
    rdchk("x5_bypass", 0, 32'hDEADBEEF, 1'b0, 4'd0);
    rdchk("x0_during", 1, 32'h0, 1'b0, 4'd0);
    step(); idle(); #1;
    rdchk("x5_reg", 0, 32'hDEADBEEF, 1'b0, 4'd0);

    issue_valid = 1'b1; issue_rd = 5'd7; issue_tag = 4'd1;
    step();
    issue_tag = 4'd2;
    step(); idle();
    commit_valid = 1'b1; commit_rd = 5'd7; commit_tag = 4'd1; commit_data = 32'h11;
    set_rd(5'd7, 5'd5);
    rdchk("x7_stale_nobyp", 0, 32'h0, 1'b1, 4'd2);
    step(); idle(); #1;
    rdchk("x7_stale", 0, 32'h11, 1'b1, 4'd2);
    commit_valid = 1'b1; commit_rd = 5'd7; commit_tag = 4'd2; commit_data = 32'h22;
    #1;
    rdchk("x7_byp", 0, 32'h22, 1'b0, 4'd0);
    step(); idle(); #1;
    rdchk("x7_done", 0, 32'h22, 1'b0, 4'd0);
    rdchk("x5_keep", 1, 32'hDEADBEEF, 1'b0, 4'd0);

    issue_valid = 1'b1; issue_rd = 5'd9; issue_tag = 4'd6;
    step(); idle();
    issue_valid = 1'b1; issue_rd = 5'd9; issue_tag = 4'd4;
    commit_valid = 1'b1; commit_rd = 5'd9; commit_tag = 4'd6; commit_data = 32'h55;
    set_rd(5'd9, 5'd9);
    rdchk("x9_same_cyc", 1, 32'h55, 1'b0, 4'd0);
    step(); idle(); #1;
    rdchk("x9_reissued", 0, 32'h55, 1'b1, 4'd4);

    issue_valid = 1'b1; issue_rd = 5'd3; issue_tag = 4'd1;
    step();
    issue_rd = 5'd4; issue_tag = 4'd2;
    step(); idle();
    set_rd(5'd3, 5'd4);
    rdchk("x3_busy", 0, 32'h0, 1'b1, 4'd1);
    rdchk("x4_busy", 1, 32'h0, 1'b1, 4'd2);
    flush = 1'b1;
    commit_valid = 1'b1; commit_rd = 5'd3; commit_tag = 4'd9; commit_data = 32'h77;
    issue_valid = 1'b1; issue_rd = 5'd6; issue_tag = 4'd5;
    step(); idle();
    set_rd(5'd3, 5'd4);
    rdchk("flush_x3", 0, 32'h77, 1'b0, 4'd0);
    rdchk("flush_x4", 1, 32'h0, 1'b0, 4'd0);
    set_rd(5'd6, 5'd9);
    rdchk("flush_x6", 0, 32'h0, 1'b0, 4'd0);
    rdchk("flush_x9", 1, 32'h55, 1'b0, 4'd0);

    issue_valid = 1'b1; issue_rd = 5'd10; issue_tag = 4'd7;
    step(); idle();
    rdy_in = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd10; issue_tag = 4'd8;
    commit_valid = 1'b1; commit_rd = 5'd10; commit_tag = 4'd7; commit_data = 32'hAA;
    flush = 1'b1;
    set_rd(5'd10, 5'd5);
    rdchk("hold_byp", 0, 32'hAA, 1'b0, 4'd0);
    step(); step();
    idle(); rdy_in = 1'b1; #1;
    rdchk("hold_x10", 0, 32'h0, 1'b1, 4'd7);
    rdchk("hold_x5", 1, 32'hDEADBEEF, 1'b0, 4'd0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    set_rd(5'd5, 5'd10);
    rdchk("rst2_x5", 0, 32'h0, 1'b0, 4'd0);
    rdchk("rst2_x10", 1, 32'h0, 1'b0, 4'd0);
    set_rd(5'd7, 5'd3);
    rdchk("rst2_x7", 0, 32'h0, 1'b0, 4'd0);
    rdchk("rst2_x3", 1, 32'h0, 1'b0, 4'd0);

    step();
    x_chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
